mem_access_unit: RTL and testbench



---
 rtl/mem_access_unit_if.sv | 29 ++
 rtl/mem_access_unit.sv | 190 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM-stage access unit and the memory.
//   master (access unit): drives dmem_req/we/addr/wstrb/wdata,
//                         samples dmem_gnt/rvalid/rdata.
//   slave  (memory)     : the mirror image.
// Request fields are valid only while dmem_req is high and stay stable until
// dmem_gnt. dmem_rvalid returns one response per granted request, for loads
// and stores alike.
interface mem_access_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [3:0]      dmem_wstrb;
    logic [XLEN-1:0] dmem_wdata;
    logic            dmem_gnt;
    logic            dmem_rvalid;
    logic [XLEN-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit (RV32I).
// Takes load/store control, address and store data from EX/MEM, runs a
// req/gnt/rvalid transaction on the data bus, returns the sign/zero-extended
// load value and stalls EX/MEM and upstream while an access is in flight.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   flush               cancel the current access (trap / redirect)
//   MEM_memory_read/write, MEM_funct3, MEM_alu_result, MEM_read_data2
//                       access request from EX/MEM
//   dmem                data-memory bus (mem_access_unit_if.master)
//   MEM_load_data       registered, extended load result
//   MEM_stall           hold EX/MEM and upstream
//   MEM_access_done     one-cycle pulse when an access retires
//   MEM_misaligned      misaligned-access pulse
//
// Build option MEM_MISALIGNED_TRAP_EN: misaligned halfword/word accesses are
// not issued and raise MEM_misaligned for one cycle. Without it the low
// address bits below the access size are ignored and MEM_misaligned is 0.
module mem_access_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                MEM_memory_read,
    input  logic                MEM_memory_write,
    input  logic [2:0]          MEM_funct3,
    input  logic [XLEN-1:0]     MEM_alu_result,
    input  logic [XLEN-1:0]     MEM_read_data2,
    mem_access_unit_if.master   dmem,
    output logic [XLEN-1:0]     MEM_load_data,
    output logic                MEM_stall,
    output logic                MEM_access_done,
    output logic                MEM_misaligned
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] load_data_q, load_data_d;
    logic            discard_q, discard_d;
`ifdef MEM_MISALIGNED_TRAP_EN
    logic            misaligned_q, misaligned_d;
`endif

    logic            access;
    logic            is_load;
    logic            aligned;
    logic [1:0]      off;
    logic [3:0]      strb;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] rdata_shift;
    logic [XLEN-1:0] load_ext;
    logic            in_req;

    // Decode: effective lane offset, alignment, store lanes, load extraction.
    always_comb begin
        access  = MEM_memory_read | MEM_memory_write;
        // A simultaneous read+write is treated as a store.
        is_load = MEM_memory_read & ~MEM_memory_write;

        // Offset already drops the bits below the access size, so the
        // no-trap build simply ignores them.
        case (MEM_funct3[1:0])
            2'b00:   off = MEM_alu_result[1:0];
            2'b01:   off = {MEM_alu_result[1], 1'b0};
            default: off = 2'b00;
        endcase

`ifdef MEM_MISALIGNED_TRAP_EN
        case (MEM_funct3[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~MEM_alu_result[0];
            default: aligned = ~|MEM_alu_result[1:0];
        endcase
`else
        aligned = 1'b1;
`endif

        case (MEM_funct3[1:0])
            2'b00: begin
                strb  = 4'b0001 << off;
                wdata = {(XLEN/8){MEM_read_data2[7:0]}};
            end
            2'b01: begin
                strb  = 4'b0011 << off;
                wdata = {(XLEN/16){MEM_read_data2[15:0]}};
            end
            default: begin
                strb  = 4'b1111;
                wdata = MEM_read_data2;
            end
        endcase

        rdata_shift = dmem.dmem_rdata >> {off, 3'b000};
        case (MEM_funct3)
            3'b000:  load_ext = {{(XLEN-8){rdata_shift[7]}}, rdata_shift[7:0]};
            3'b001:  load_ext = {{(XLEN-16){rdata_shift[15]}}, rdata_shift[15:0]};
            3'b100:  load_ext = {{(XLEN-8){1'b0}}, rdata_shift[7:0]};
            3'b101:  load_ext = {{(XLEN-16){1'b0}}, rdata_shift[15:0]};
            default: load_ext = rdata_shift;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d     = state_q;
        load_data_d = load_data_q;
        discard_d   = discard_q;
`ifdef MEM_MISALIGNED_TRAP_EN
        misaligned_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                discard_d = 1'b0;
                if (access && aligned && !flush) state_d = REQ;
`ifdef MEM_MISALIGNED_TRAP_EN
                misaligned_d = access & ~aligned;
`endif
            end
            REQ: begin
                if (dmem.dmem_gnt) begin
                    state_d = RESP;
                    if (flush) discard_d = 1'b1;
                end else if (flush) begin
                    state_d = IDLE;
                end
            end
            RESP: begin
                // A flush here cannot cancel the bus transaction; the
                // response drains and its data is dropped.
                if (flush) discard_d = 1'b1;
                if (dmem.dmem_rvalid) begin
                    state_d = DONE;
                    if (is_load && !discard_q && !flush) load_data_d = load_ext;
                end
            end
            DONE: begin
                // EX/MEM still holds the retired instruction this cycle;
                // returning unconditionally to IDLE prevents a re-issue.
                state_d   = IDLE;
                discard_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            load_data_q <= '0;
            discard_q   <= 1'b0;
`ifdef MEM_MISALIGNED_TRAP_EN
            misaligned_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            load_data_q <= load_data_d;
            discard_q   <= discard_d;
`ifdef MEM_MISALIGNED_TRAP_EN
            misaligned_q <= misaligned_d;
`endif
        end
    end

    // Bus fields are gated by REQ so the bus is all-zero outside a request.
    always_comb begin
        in_req          = (state_q == REQ);
        dmem.dmem_req   = in_req;
        dmem.dmem_we    = in_req & MEM_memory_write;
        dmem.dmem_addr  = in_req ? {MEM_alu_result[XLEN-1:2], 2'b00} : '0;
        dmem.dmem_wstrb = (in_req && MEM_memory_write) ? strb : '0;
        dmem.dmem_wdata = (in_req && MEM_memory_write) ? wdata : '0;

        // A flush in REQ without grant abandons the request, so the stall
        // drops in that same cycle.
        MEM_stall = ((state_q == IDLE) && access && aligned && !flush)
                  | (in_req && !(flush && !dmem.dmem_gnt))
                  | (state_q == RESP);
        MEM_access_done = (state_q == DONE) && !discard_q;
        MEM_load_data   = load_data_q;
`ifdef MEM_MISALIGNED_TRAP_EN
        MEM_misaligned  = misaligned_q;
`else
        MEM_misaligned  = 1'b0;
`endif
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit. A memory responder with
// programmable grant/response latency drives the bus; expected bus requests
// and load results are queued when an access is presented and compared when
// the DUT produces them.
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        MEM_memory_read;
    logic        MEM_memory_write;
    logic [2:0]  MEM_funct3;
    logic [31:0] MEM_alu_result;
    logic [31:0] MEM_read_data2;
    logic [31:0] MEM_load_data;
    logic        MEM_stall;
    logic        MEM_access_done;
    logic        MEM_misaligned;

    mem_access_unit_if #(.XLEN(32)) dmem_bus ();

    mem_access_unit #(.XLEN(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .flush            (flush),
        .MEM_memory_read  (MEM_memory_read),
        .MEM_memory_write (MEM_memory_write),
        .MEM_funct3       (MEM_funct3),
        .MEM_alu_result   (MEM_alu_result),
        .MEM_read_data2   (MEM_read_data2),
        .dmem             (dmem_bus),
        .MEM_load_data    (MEM_load_data),
        .MEM_stall        (MEM_stall),
        .MEM_access_done  (MEM_access_done),
        .MEM_misaligned   (MEM_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_txn_t;

    bus_txn_t    bus_q[$];
    logic [31:0] ld_q[$];
    logic [31:0] model_ld;
    int          checks;
    int          failures;

    localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010,
                           F_BU = 3'b100, F_HU = 3'b101;

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[8*a[1:0] +: 8];
        h = a[1] ? rd[31:16] : rd[15:0];
        case (f3)
            F_B:     return {{24{b[7]}}, b};
            F_BU:    return {24'h0, b};
            F_H:     return {{16{h[15]}}, h};
            F_HU:    return {16'h0, h};
            default: return rd;
        endcase
    endfunction

    function automatic bus_txn_t exp_bus(input logic wr, input logic [2:0] f3,
                                         input logic [31:0] a, input logic [31:0] sd);
        bus_txn_t t;
        t.we    = wr;
        t.addr  = {a[31:2], 2'b00};
        t.wstrb = 4'b0000;
        t.wdata = 32'h0;
        if (wr) begin
            case (f3[1:0])
                2'b00:   begin t.wstrb = 4'b0001 << a[1:0];        t.wdata = {4{sd[7:0]}};  end
                2'b01:   begin t.wstrb = a[1] ? 4'b1100 : 4'b0011; t.wdata = {2{sd[15:0]}}; end
                default: begin t.wstrb = 4'b1111;                  t.wdata = sd;            end
            endcase
        end
        return t;
    endfunction

    function automatic bit exp_misaligned(input logic [2:0] f3, input logic [31:0] a);
`ifdef MEM_MISALIGNED_TRAP_EN
        case (f3[1:0])
            2'b00:   return 1'b0;
            2'b01:   return a[0];
            default: return |a[1:0];
        endcase
`else
        return 1'b0;
`endif
    endfunction

    // Presents one access and plays the memory. flush_at is the cycle index
    // (0 = presenting cycle) in which flush is pulsed, -1 for none.
    task automatic run_access(input logic rd_i, input logic wr_i, input logic [2:0] f3_i,
                              input logic [31:0] a_i, input logic [31:0] sd_i,
                              input logic [31:0] rdat_i, input int gd, input int rdly,
                              input int flush_at, output int stall_n, output int done_n,
                              output int req_n);
        bus_txn_t    e;
        logic [31:0] first_addr;
        bit          granted, responded, exit_now, first, issued;
        int          resp_cnt;
        stall_n = 0; done_n = 0; req_n = 0;
        granted = 0; responded = 0; exit_now = 0; first = 1; resp_cnt = 0;
        first_addr = 32'h0;
        issued = (flush_at != 0) && !exp_misaligned(f3_i, a_i);
        if (issued) bus_q.push_back(exp_bus(wr_i, f3_i, a_i, sd_i));
        if (issued && rd_i && !wr_i && flush_at < 0) model_ld = exp_load(f3_i, a_i, rdat_i);
        ld_q.push_back(model_ld);

        @(negedge clk);
        MEM_memory_read  = rd_i;
        MEM_memory_write = wr_i;
        MEM_funct3       = f3_i;
        MEM_alu_result   = a_i;
        MEM_read_data2   = sd_i;
        for (int cyc = 0; cyc < 40; cyc++) begin
            flush = (cyc == flush_at);
            dmem_bus.dmem_gnt    = 1'b0;
            dmem_bus.dmem_rvalid = 1'b0;
            if (granted && !responded) begin
                if (resp_cnt >= rdly) begin
                    dmem_bus.dmem_rvalid = 1'b1;
                    dmem_bus.dmem_rdata  = rdat_i;
                    responded = 1;
                end
                resp_cnt++;
            end
            if (dmem_bus.dmem_req) begin
                req_n++;
                if (first) begin
                    first = 0;
                    first_addr = dmem_bus.dmem_addr;
                    checks++;
                    if (bus_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_req addr=%h expected no request", dmem_bus.dmem_addr);
                    end else begin
                        e = bus_q.pop_front();
                        if (dmem_bus.dmem_addr !== e.addr || dmem_bus.dmem_we !== e.we ||
                            dmem_bus.dmem_wstrb !== e.wstrb || (e.we && dmem_bus.dmem_wdata !== e.wdata)) begin
                            failures++;
                            $display("FAIL bus_fields got we=%b addr=%h wstrb=%b wdata=%h expected we=%b addr=%h wstrb=%b wdata=%h",
                                     dmem_bus.dmem_we, dmem_bus.dmem_addr, dmem_bus.dmem_wstrb, dmem_bus.dmem_wdata,
                                     e.we, e.addr, e.wstrb, e.wdata);
                        end
                    end
                end else begin
                    checks++;
                    if (dmem_bus.dmem_addr !== first_addr) begin
                        failures++;
                        $display("FAIL addr_stable got %h expected %h", dmem_bus.dmem_addr, first_addr);
                    end
                end
                if (req_n > gd) begin
                    dmem_bus.dmem_gnt = 1'b1;
                    granted = 1;
                end
            end
            if (MEM_access_done) begin
                done_n++;
                checks++;
                if (MEM_load_data !== ld_q[0]) begin
                    failures++;
                    $display("FAIL load_data_at_done got %h expected %h", MEM_load_data, ld_q[0]);
                end
            end
            #1;
            if (MEM_stall) stall_n++;
            else exit_now = 1;
            @(negedge clk);
            if (exit_now) break;
        end
        MEM_memory_read  = 1'b0;
        MEM_memory_write = 1'b0;
        flush            = 1'b0;
        dmem_bus.dmem_gnt    = 1'b0;
        dmem_bus.dmem_rvalid = 1'b0;
        checks++;
        if (!exit_now) begin
            failures++;
            $display("FAIL timeout stall still high after 40 cycles expected release");
        end
        checks++;
        e.addr = ld_q.pop_front();
        if (MEM_load_data !== e.addr) begin
            failures++;
            $display("FAIL load_data_held got %h expected %h", MEM_load_data, e.addr);
        end
        checks++;
        if (bus_q.size() != 0) begin
            failures++;
            $display("FAIL missing_req got no request expected %0d", bus_q.size());
            bus_q.delete();
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_wstrb, dmem_bus.dmem_addr} !== 38'h0) begin
            failures++;
            $display("FAIL reset_bus got req=%b we=%b wstrb=%b addr=%h expected all 0",
                     dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_wstrb, dmem_bus.dmem_addr);
        end
        checks++;
        if (MEM_load_data !== 32'h0 || MEM_stall !== 1'b0 || MEM_access_done !== 1'b0 || MEM_misaligned !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got ld=%h stall=%b done=%b mis=%b expected 0 0 0 0",
                     MEM_load_data, MEM_stall, MEM_access_done, MEM_misaligned);
        end
        reset = 1'b1;
        model_ld = 32'h0;
        @(negedge clk);
    endtask

    task automatic test_load_word;
        int s, d, r;
        run_access(1, 0, F_W, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, -1, s, d, r);
        checks++;
        if (s != 3 || d != 1 || r != 1) begin
            failures++;
            $display("FAIL lw_zero_wait got stall=%0d done=%0d req=%0d expected 3 1 1", s, d, r);
        end
    endtask

    task automatic test_load_extend;
        int s, d, r;
        logic [2:0]  f3s[4] = '{F_B, F_BU, F_HU, F_H};
        logic [31:0] as[4]  = '{32'h103, 32'h103, 32'h102, 32'h102};
        logic [31:0] req_vals[4] = '{32'hFFFFFF80, 32'h00000080, 32'h000080FF, 32'hFFFF80FF};
        for (int i = 0; i < 4; i++) begin
            run_access(1, 0, f3s[i], as[i], 32'h0, 32'h80FF0011, 0, 0, -1, s, d, r);
            checks++;
            if (d != 1 || MEM_load_data !== req_vals[i]) begin
                failures++;
                $display("FAIL load_ext_%0d got ld=%h done=%0d expected %h 1", i, MEM_load_data, d, req_vals[i]);
            end
        end
    endtask

    task automatic test_store;
        int s, d, r;
        run_access(0, 1, F_B, 32'h201, 32'h000000AB, 32'h0, 0, 0, -1, s, d, r);
        run_access(0, 1, F_H, 32'h202, 32'h00001234, 32'h0, 0, 0, -1, s, d, r);
        run_access(0, 1, F_W, 32'h204, 32'hCAFEF00D, 32'h0, 1, 1, -1, s, d, r);
        checks++;
        if (s != 5 || d != 1) begin
            failures++;
            $display("FAIL sw_wait got stall=%0d done=%0d expected 5 1", s, d);
        end
    endtask

    task automatic test_wait_states;
        int s, d, r;
        run_access(1, 0, F_W, 32'h180, 32'h0, 32'h13579BDF, 3, 2, -1, s, d, r);
        checks++;
        if (s != 8 || d != 1 || r != 4) begin
            failures++;
            $display("FAIL wait_states got stall=%0d done=%0d req=%0d expected 8 1 4", s, d, r);
        end
    endtask

    task automatic test_flush;
        int s, d, r;
        run_access(1, 0, F_W, 32'h300, 32'h0, 32'h00000011, 0, 0, -1, s, d, r);
        run_access(1, 0, F_W, 32'h304, 32'h0, 32'h55555555, 0, 2, 2, s, d, r);
        checks++;
        if (s != 5 || d != 0 || MEM_load_data !== 32'h11) begin
            failures++;
            $display("FAIL flush_resp got stall=%0d done=%0d ld=%h expected 5 0 00000011", s, d, MEM_load_data);
        end
        run_access(1, 0, F_W, 32'h308, 32'h0, 32'h66666666, 5, 0, 2, s, d, r);
        checks++;
        if (s != 2 || d != 0 || r != 2 || dmem_bus.dmem_req !== 1'b0) begin
            failures++;
            $display("FAIL flush_req got stall=%0d done=%0d req=%0d req_now=%b expected 2 0 2 0",
                     s, d, r, dmem_bus.dmem_req);
        end
        run_access(0, 1, F_W, 32'h30C, 32'h77, 32'h0, 0, 0, 0, s, d, r);
        checks++;
        if (s != 0 || d != 0 || r != 0) begin
            failures++;
            $display("FAIL flush_idle got stall=%0d done=%0d req=%0d expected 0 0 0", s, d, r);
        end
    endtask

    task automatic test_misaligned;
        int s, d, r;
        run_access(1, 0, F_W, 32'h102, 32'h0, 32'h01234567, 0, 0, -1, s, d, r);
`ifdef MEM_MISALIGNED_TRAP_EN
        checks++;
        if (s != 0 || r != 0 || MEM_misaligned !== 1'b1) begin
            failures++;
            $display("FAIL misaligned_trap got stall=%0d req=%0d mis=%b expected 0 0 1", s, r, MEM_misaligned);
        end
        @(negedge clk);
        checks++;
        if (MEM_misaligned !== 1'b0) begin
            failures++;
            $display("FAIL misaligned_pulse got %b expected 0", MEM_misaligned);
        end
`else
        checks++;
        if (s != 3 || d != 1 || MEM_misaligned !== 1'b0 || MEM_load_data !== 32'h01234567) begin
            failures++;
            $display("FAIL misaligned_ignored got stall=%0d done=%0d mis=%b ld=%h expected 3 1 0 01234567",
                     s, d, MEM_misaligned, MEM_load_data);
        end
`endif
    endtask

    task automatic test_reset_mid_access;
        @(negedge clk);
        MEM_memory_read = 1'b1;
        MEM_funct3      = F_W;
        MEM_alu_result  = 32'h400;
        dmem_bus.dmem_gnt = 1'b0;
        @(negedge clk);
        checks++;
        if (dmem_bus.dmem_req !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_req_before got %b expected 1", dmem_bus.dmem_req);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (dmem_bus.dmem_req !== 1'b0 || MEM_load_data !== 32'h0) begin
            failures++;
            $display("FAIL mid_reset_async got req=%b ld=%h expected 0 00000000", dmem_bus.dmem_req, MEM_load_data);
        end
        MEM_memory_read = 1'b0;
        model_ld = 32'h0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        model_ld = 32'h0;
        reset = 1'b0;
        flush = 1'b0;
        MEM_memory_read  = 1'b0;
        MEM_memory_write = 1'b0;
        MEM_funct3       = 3'b000;
        MEM_alu_result   = 32'h0;
        MEM_read_data2   = 32'h0;
        dmem_bus.dmem_gnt    = 1'b0;
        dmem_bus.dmem_rvalid = 1'b0;
        dmem_bus.dmem_rdata  = 32'h0;

        test_reset();
        test_load_word();
        test_load_extend();
        test_store();
        test_wait_states();
        test_flush();
        test_misaligned();
        test_reset_mid_access();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
